// File: rtl/process_images_udiv_61ns_31ns_61_seq.sv
// process_images_udiv_61ns_31ns_61_seq
// Sequential radix-2 restoring unsigned divider, 61-bit dividend / 31-bit divisor.
// One quotient bit is produced per enabled cycle. A start/done handshake is used,
// and ce freezes all state.
// Optional build macro UDIV_DIV_ZERO_FLAG_EN adds a registered div_zero output.
// This output flags a zero divisor captured on the accepted start.
module process_images_udiv_61ns_31ns_61_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 61,
  parameter int din1_WIDTH = 31,
  parameter int dout_WIDTH = 61
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  idle,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
`ifdef UDIV_DIV_ZERO_FLAG_EN
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero
`else
  output logic [din1_WIDTH-1:0] rem
`endif
);

  localparam int CNT_W = $clog2(din0_WIDTH + 1);
  // The counter reaches this value once every dividend bit has been consumed.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(din0_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [din0_WIDTH-1:0] dividend;
  logic [din1_WIDTH-1:0] divisor;
  logic [din1_WIDTH-1:0] pr;
  logic [din0_WIDTH-1:0] quot;
  logic [CNT_W-1:0]      counter;

  // One restoring step. The compare and subtract are one bit wider than the divisor,
  // so the shifted partial remainder can never overflow.
  logic [din1_WIDTH:0]   pr_shift;
  logic [din1_WIDTH:0]   divisor_ext;
  logic [din1_WIDTH:0]   pr_diff;
  logic                  q_bit;
  logic [din1_WIDTH-1:0] pr_next;

  // Combinational single iteration of the restoring divider.
  always_comb begin
    pr_shift    = {pr, dividend[din0_WIDTH-1]};
    divisor_ext = {1'b0, divisor};
    pr_diff     = pr_shift - divisor_ext;
    q_bit       = (pr_shift >= divisor_ext);
    if (q_bit) begin
      pr_next = pr_diff[din1_WIDTH-1:0];
    end else begin
      pr_next = pr_shift[din1_WIDTH-1:0];
    end
  end

  // State register: synchronous active-low reset, frozen while ce is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else if (ce) begin
      state <= state_next;
    end else begin
      state <= state;
    end
  end

  // Next-state logic. BUSY spends one final cycle publishing the results after the last iteration.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_BUSY;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (counter == LAST_CNT) begin
          state_next = S_DONE;
        end else begin
          state_next = S_BUSY;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    idle = 1'b0;
    done = 1'b0;
    case (state)
      S_IDLE:  idle = 1'b1;
      S_BUSY:  idle = 1'b0;
      S_DONE:  done = 1'b1;
      default: idle = 1'b0;
    endcase
  end

  // Datapath: operand capture, one iteration per enabled BUSY cycle, and result publication.
  // dout and rem are only written on the final BUSY cycle, so they hold between divisions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dividend <= '0;
      divisor  <= '0;
      pr       <= '0;
      quot     <= '0;
      counter  <= '0;
      dout     <= '0;
      rem      <= '0;
    end else if (ce) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dividend <= din0;
            divisor  <= din1;
            pr       <= '0;
            quot     <= '0;
            counter  <= '0;
          end
        end
        S_BUSY: begin
          if (counter != LAST_CNT) begin
            pr       <= pr_next;
            quot     <= {quot[din0_WIDTH-2:0], q_bit};
            dividend <= {dividend[din0_WIDTH-2:0], 1'b0};
            counter  <= counter + CNT_W'(1);
          end else begin
            dout <= quot;
            rem  <= pr;
          end
        end
        default: begin
          counter <= counter;
        end
      endcase
    end
  end

`ifdef UDIV_DIV_ZERO_FLAG_EN
  // Zero-divisor flag captured with the operands and held until the next accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_zero <= 1'b0;
    end else if (ce && (state == S_IDLE) && start) begin
      div_zero <= (din1 == '0);
    end else begin
      div_zero <= div_zero;
    end
  end
`endif

endmodule

// File: tb/tb_process_images_udiv_61ns_31ns_61_seq.sv
// Directed self-checking bench for process_images_udiv_61ns_31ns_61_seq.
// Expected quotients, remainders and latencies are hand-computed constants.
module tb_process_images_udiv_61ns_31ns_61_seq;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        start;
  logic [60:0] din0;
  logic [30:0] din1;
  logic        idle;
  logic        done;
  logic [60:0] dout;
  logic [30:0] rem;
`ifdef UDIV_DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  process_images_udiv_61ns_31ns_61_seq #(
    .ID(1), .din0_WIDTH(61), .din1_WIDTH(31), .dout_WIDTH(61)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .idle(idle), .done(done),
`ifdef UDIV_DIV_ZERO_FLAG_EN
    .dout(dout), .rem(rem), .div_zero(div_zero)
`else
    .dout(dout), .rem(rem)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_view(input string tag);
    check({tag, "_idle"}, 64'(idle), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_dout"}, 64'(dout), 64'd0);
    check({tag, "_rem"},  64'(rem),  64'd0);
  endtask

  // Starts a division and counts every clock edge until done appears.
  // Edges stall_at+1 .. stall_at+stall_len run with ce=0. Edge ignore_at carries a stray start with other operands.
  task automatic run_div(input string tag, input logic [60:0] a, input logic [30:0] b,
                         input int stall_at, input int stall_len, input int ignore_at,
                         input logic [60:0] exp_q, input logic [30:0] exp_r,
                         input int exp_lat, input logic exp_dz);
    int lat;
    lat = 0;
    check({tag, "_idle_before"}, 64'(idle), 64'd1);
    start = 1'b1;
    din0  = a;
    din1  = b;
    tick();
    start = 1'b0;
    din0  = 61'd0;
    din1  = 31'd0;
    for (int k = 1; k <= 300; k++) begin
      ce = !((k > stall_at) && (k <= stall_at + stall_len));
      if (k == ignore_at) begin
        start = 1'b1;
        din0  = 61'd50;
        din1  = 31'd5;
      end
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    ce = 1'b1;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_dout"}, 64'(dout), 64'(exp_q));
    check({tag, "_rem"}, 64'(rem), 64'(exp_r));
    check({tag, "_idle_in_done"}, 64'(idle), 64'd0);
`ifdef UDIV_DIV_ZERO_FLAG_EN
    check({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
`else
    if (exp_dz !== 1'b0 && exp_dz !== 1'b1) $display("note: unexpected flag value");
`endif
    tick();
    check({tag, "_idle_after"}, 64'(idle), 64'd1);
    check({tag, "_done_after"}, 64'(done), 64'd0);
    check({tag, "_dout_hold"}, 64'(dout), 64'(exp_q));
    check({tag, "_rem_hold"}, 64'(rem), 64'(exp_r));
  endtask

  initial begin
    logic saw_done;
    reset = 1'b0;
    ce    = 1'b1;
    start = 1'b0;
    din0  = 61'd0;
    din1  = 31'd0;

    // Reset held for three cycles, then released idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_view("reset_hold");
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_view("reset_release");
    end

    // 100 / 7 = 14 r 2
    run_div("basic", 61'd100, 31'd7, 0, 0, 0, 61'd14, 31'd2, 62, 1'b0);

    // (2^61-1) / (2^31-1) = 2^30 r 2^30-1
    run_div("max", 61'h1FFF_FFFF_FFFF_FFFF, 31'h7FFF_FFFF, 0, 0, 0,
            61'h0000_0000_4000_0000, 31'h3FFF_FFFF, 62, 1'b0);

    // Divide by zero: quotient all ones, remainder = low dividend bits.
    run_div("div0", 61'd12345, 31'd0, 0, 0, 0,
            61'h1FFF_FFFF_FFFF_FFFF, 31'd12345, 62, 1'b1);
    run_div("after_div0", 61'd10, 31'd3, 0, 0, 0, 61'd3, 31'd1, 62, 1'b0);

    // ce low for ten edges mid-BUSY and a stray start during BUSY.
    run_div("stall", 61'd100, 31'd7, 20, 10, 10, 61'd14, 31'd2, 72, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1 || idle !== 1'b1) saw_done = 1'b1;
    end
    check("stall_no_second_op", 64'(saw_done), 64'd0);

    // Reset at BUSY iteration 20 aborts the division.
    start = 1'b1;
    din0  = 61'd1000;
    din1  = 31'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("midrst_busy", 64'(idle), 64'd0);
    reset = 1'b0;
    tick();
    check_reset_view("midrst_in_reset");
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", 64'(saw_done), 64'd0);
    check_reset_view("midrst_after");

    // 1000 / 3 = 333 r 1
    run_div("after_midrst", 61'd1000, 31'd3, 0, 0, 0, 61'd333, 31'd1, 62, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/process_images_udiv_61ns_31ns_61_seq.md
Name: process_images_udiv_61ns_31ns_61_seq

Overview:
- Sequential unsigned divider; the inverse of the pipelined 31x31->61 unsigned multiplier in the process_images datapath.
- Takes a 61-bit unsigned dividend (e.g. an accumulated product) and a 31-bit unsigned divisor.
- Returns a 61-bit quotient and a 31-bit remainder after a fixed multi-cycle latency.
- Radix-2 restoring algorithm, one quotient bit per cycle. Uses a start/done handshake and the same `ce` clock-enable semantics as the multiplier cores.

Parameters:
- ID, 1, instance identifier; no functional effect.
- din0_WIDTH, 61, dividend and quotient width.
- din1_WIDTH, 31, divisor and remainder width.
- dout_WIDTH, 61, quotient output width; must equal din0_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- ce  in  1  clock enable. When low, all state is frozen.
- start  in  1  request to begin a division. Sampled only in IDLE with ce=1.
- din0  in  din0_WIDTH  dividend. Captured on the accepted start.
- din1  in  din1_WIDTH  divisor. Captured on the accepted start.
- idle  out  1  high in IDLE; the block can accept start.
- done  out  1  one-cycle pulse (per enabled cycle) when results become valid.
- dout  out  dout_WIDTH  quotient.
- rem  out  din1_WIDTH  remainder.

Behaviour:
- Reset (reset=0 at a clk edge; overrides ce):
  - state=IDLE, counter=0, idle=1, done=0, dout=0, rem=0.
  - Internal dividend, divisor and partial-remainder registers are cleared.
- Clock enable: nothing updates on an edge with ce=0, including counter, state and outputs. Outputs hold their values.
- States:
  - IDLE: idle=1.
    - start=1 & ce=1: capture din0 and din1, partial remainder := 0, counter := 0, go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY: idle=0. Each enabled edge performs one iteration:
    - pr' = {pr, dividend MSB}, which is din1_WIDTH+1 bits wide.
    - If pr' >= divisor: pr := pr' - divisor and shift 1 into the quotient. Else pr := pr' and shift 0 into the quotient.
    - Dividend shifts left by 1; counter increments.
    - After the din0_WIDTH-th iteration, go to DONE.
  - DONE: done=1, idle=0. dout=quotient, rem=partial remainder (low din1_WIDTH bits). Next enabled edge goes to IDLE.
- Output hold: dout and rem hold their values until the next DONE. They are not cleared when leaving DONE.
- Latency: start accepted at edge N -> done=1 during the cycle after edge N+din0_WIDTH+1. That is din0_WIDTH+2 enabled cycles from start to done (62 with defaults), plus any cycles where ce=0.
- Throughput: one division per din0_WIDTH+3 enabled cycles. This includes the return to IDLE.
- start ignored:
  - start in BUSY or DONE is ignored and has no side effect. It must be reasserted in IDLE.
  - start held high continuously starts a new division on every IDLE cycle.
- Divisor = 0: the natural restoring result applies, with no special case in the datapath:
  - quotient = all ones.
  - rem = low din1_WIDTH bits of the dividend.
- Reset mid-operation: the division is aborted and reset values apply. No done pulse is produced for the aborted request.
- Width rule: partial-remainder compare and subtract are din1_WIDTH+1 bits wide, so no overflow is possible.

Optional Feature:
- Macro: UDIV_DIV_ZERO_FLAG_EN.
- When defined:
  - Adds output port `div_zero` (1 bit).
  - Registered on the accepted start as (din1==0). Held until the next accepted start.
  - Cleared to 0 by reset.
  - Valid when done=1.
  - Quotient and remainder are unchanged from the base behaviour.
- When undefined: the port and its register are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, then release with ce=1 and start=0. Required: idle=1, done=0, dout=0, rem=0 on every cycle.
- Basic divide: din0=100, din1=7, start pulse. Required:
  - done pulses exactly 62 cycles after the start edge, for 1 cycle.
  - dout=14, rem=2.
  - idle=1 on the following cycle.
- Maximum operands: din0=0x1FFF_FFFF_FFFF_FFFF, din1=0x7FFF_FFFF. Required: dout=0x4000_0000, rem=0x3FFF_FFFF.
- Divide by zero: din0=12345, din1=0. Required: dout=0x1FFF_FFFF_FFFF_FFFF, rem=12345, and div_zero=1 when UDIV_DIV_ZERO_FLAG_EN is defined. A following 10/3 gives dout=3, rem=1, div_zero=0.
- ce stall and ignored start:
  - Start 100/7, drive ce=0 for 10 cycles mid-BUSY, and pulse start during BUSY with different operands.
  - Required: done arrives exactly 72 cycles after the start edge, with dout=14, rem=2, and no second operation begins.
- Reset mid-operation: start 1000/3, assert reset=0 at BUSY iteration 20, then release.
  - Required: no done pulse; idle=1; dout=0, rem=0.
  - A new 1000/3 start then gives dout=333, rem=1.
